voice_env_sched: RTL and testbench
==================================

Name: voice_env_sched

Overview:
- Time-multiplexed envelope scheduler for the polyphonic synth voice bank.
- Holds per-voice envelope state, 18-bit volume and pending note events for NVOICE voices.
- On each audio sample tick, sweeps all voices through the shared combinational envelope stepper, one voice per clock, and writes results back.
- Streams updated per-voice volumes to the mixer and latches MIDI note press/release events between sweeps.

Parameters:
- NVOICE, 16, number of voices swept per sample tick (power of two, 2..64).
- VW, 4, voice index width, log2(NVOICE).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_tick  in  1  one-cycle pulse that starts a sweep.
- ev_valid  in  1  note event strobe, one cycle, always accepted.
- ev_voice  in  VW  target voice of the event.
- ev_press  in  1  1 = note pressed, 0 = note released.
- stp_state  out  3  state of the current voice, to the stepper.
- stp_volume  out  18  volume of the current voice, to the stepper.
- stp_pressed  out  1  pending-press flag of the current voice.
- stp_released  out  1  pending-release flag of the current voice.
- stp_next_state  in  3  stepper result, combinational from stp_*.
- stp_next_volume  in  18  stepper result.
- vol_valid  out  1  qualifies vol_voice/vol_out.
- vol_voice  out  VW  voice index of vol_out.
- vol_out  out  18  updated volume.
- busy  out  1  sweep in progress.
- sweep_done  out  1  one-cycle pulse after the last voice is written.
- overrun  out  1  one-cycle pulse when sample_tick arrives while busy.

Behaviour:
- Storage per voice: state[2:0], volume[17:0], pend_press, pend_rel (register arrays).
- State encoding: BLANK=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Reset: all arrays cleared (state BLANK, volume 0, flags 0); idx=0; FSM=IDLE; all outputs 0.
- Reset mid-sweep aborts the sweep the same cycle with no write-back; no vol_valid follows.
- FSM IDLE:
  - sample_tick -> SWEEP, idx=0, busy=1 from the next cycle.
- FSM SWEEP, each cycle:
  - stp_* driven combinationally from the arrays at idx.
  - At the clock edge, state[idx] and volume[idx] take stp_next_*.
  - pend_press[idx] and pend_rel[idx] clear.
  - vol_valid=1, vol_voice=idx, vol_out=stp_next_volume, registered (1-cycle latency).
  - idx increments; at idx==NVOICE-1 -> IDLE, sweep_done=1 the next cycle, busy=0.
  - Sweep length is exactly NVOICE cycles, voices in ascending order.
- In IDLE: stp_* present voice 0 values; stepper outputs ignored; vol_valid=0.
- Events:
  - ev_press=1 sets pend_press and clears pend_rel; ev_press=0 sets pend_rel and clears pend_press (latest event wins).
  - An event to the voice being swept in the same cycle: the set takes priority over the sweep clear, so the event stays pending for the next sweep. The stepper sees the pre-event flags in that cycle.
  - Events to any other voice are unaffected by the sweep.
- Overrun: sample_tick while busy (including the sweep_done cycle) is dropped and overrun pulses; the sweep in progress continues unchanged.
- sample_tick coincident with rst: reset wins.

Test Plan:
- Reset, then observe 3 ticks with no events -> each sweep gives 16 vol_valid beats, voices 0..15 in order, vol_out=0, sweep_done 16 cycles after the first beat.
- Stepper attached, attack_rate=8, velocity=127: press voice 3, tick -> voice 3 state 1, vol_out 0. Next tick -> vol_out 8. Next tick -> 16. All other voices stay 0.
- Press voice 5 in the exact cycle idx=5 is swept -> voice 5 stays BLANK that sweep and enters ATTACK on the next sweep; pend_press is not lost.
- Press then release voice 2 before a tick -> only stp_released=1 is presented for voice 2 (latest event wins).
- sample_tick again 4 cycles into a sweep -> overrun=1 for one cycle, the sweep completes with 16 beats, and no second sweep starts.
- Assert rst at idx=7 -> no further vol_valid, all states and volumes read 0 on the next sweep, busy=0 one cycle after rst.

Source files
------------

// File: rtl/voice_env_sched.sv
// Time-multiplexed envelope scheduler: holds per-voice envelope state and pending
// note events, and sweeps every voice through an external stepper once per sample tick.
module voice_env_sched #(
    parameter int NVOICE = 16,
    parameter int VW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_tick,
    input  logic          ev_valid,
    input  logic [VW-1:0] ev_voice,
    input  logic          ev_press,
    output logic [2:0]    stp_state,
    output logic [17:0]   stp_volume,
    output logic          stp_pressed,
    output logic          stp_released,
    input  logic [2:0]    stp_next_state,
    input  logic [17:0]   stp_next_volume,
    output logic          vol_valid,
    output logic [VW-1:0] vol_voice,
    output logic [17:0]   vol_out,
    output logic          busy,
    output logic          sweep_done,
    output logic          overrun
);
    typedef enum logic {IDLE, SWEEP} fsm_t;

    localparam logic [VW-1:0] LAST_IDX = VW'(NVOICE - 1);

    fsm_t          fsm_q, fsm_d;
    logic [VW-1:0] idx_q, idx_d;
    logic          vol_valid_q, vol_valid_d;
    logic [VW-1:0] vol_voice_q, vol_voice_d;
    logic [17:0]   vol_out_q, vol_out_d;
    logic          sweep_done_q, sweep_done_d;
    logic          overrun_q, overrun_d;

    logic [2:0]    state_rd  [NVOICE];
    logic [17:0]   volume_rd [NVOICE];
    logic          press_rd  [NVOICE];
    logic          rel_rd    [NVOICE];

    always_comb begin
        fsm_d        = fsm_q;
        idx_d        = idx_q;
        vol_valid_d  = 1'b0;
        vol_voice_d  = vol_voice_q;
        vol_out_d    = vol_out_q;
        overrun_d    = 1'b0;
        sweep_done_d = vol_valid_q && (vol_voice_q == LAST_IDX);
        case (fsm_q)
            IDLE: begin
                // The sweep_done cycle still counts as busy for tick acceptance.
                if (sample_tick) begin
                    if (sweep_done_q) begin
                        overrun_d = 1'b1;
                    end else begin
                        fsm_d = SWEEP;
                        idx_d = '0;
                    end
                end
            end
            SWEEP: begin
                vol_valid_d = 1'b1;
                vol_voice_d = idx_q;
                vol_out_d   = stp_next_volume;
                overrun_d   = sample_tick;
                if (idx_q == LAST_IDX) begin
                    fsm_d = IDLE;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= IDLE;
            idx_q        <= '0;
            vol_valid_q  <= 1'b0;
            vol_voice_q  <= '0;
            vol_out_q    <= '0;
            sweep_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            idx_q        <= idx_d;
            vol_valid_q  <= vol_valid_d;
            vol_voice_q  <= vol_voice_d;
            vol_out_q    <= vol_out_d;
            sweep_done_q <= sweep_done_d;
            overrun_q    <= overrun_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NVOICE; gi++) begin : g_voice
            logic [2:0]  state_q, state_d;
            logic [17:0] volume_q, volume_d;
            logic        press_q, press_d;
            logic        rel_q, rel_d;
            logic        hit_sw, hit_ev;

            assign hit_sw = (fsm_q == SWEEP) && (idx_q == VW'(gi));
            assign hit_ev = ev_valid && (ev_voice == VW'(gi));

            // A new event overrides the sweep's clear so it survives to the next sweep.
            always_comb begin
                state_d  = state_q;
                volume_d = volume_q;
                press_d  = press_q;
                rel_d    = rel_q;
                if (hit_sw) begin
                    state_d  = stp_next_state;
                    volume_d = stp_next_volume;
                    press_d  = 1'b0;
                    rel_d    = 1'b0;
                end
                if (hit_ev) begin
                    press_d = ev_press;
                    rel_d   = !ev_press;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q  <= '0;
                    volume_q <= '0;
                    press_q  <= 1'b0;
                    rel_q    <= 1'b0;
                end else begin
                    state_q  <= state_d;
                    volume_q <= volume_d;
                    press_q  <= press_d;
                    rel_q    <= rel_d;
                end
            end

            assign state_rd[gi]  = state_q;
            assign volume_rd[gi] = volume_q;
            assign press_rd[gi]  = press_q;
            assign rel_rd[gi]    = rel_q;
        end
    endgenerate

    assign stp_state    = state_rd[idx_q];
    assign stp_volume   = volume_rd[idx_q];
    assign stp_pressed  = press_rd[idx_q];
    assign stp_released = rel_rd[idx_q];

    assign vol_valid  = vol_valid_q;
    assign vol_voice  = vol_voice_q;
    assign vol_out    = vol_out_q;
    assign busy       = (fsm_q == SWEEP);
    assign sweep_done = sweep_done_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_voice_env_sched.sv
// Bench for voice_env_sched: a simple attack/release stepper is attached, and a
// per-voice model predicts every stepper presentation and every volume beat.
module tb_voice_env_sched;
    localparam int N   = 16;
    localparam int VW  = 4;
    localparam int ATK = 8;

    logic          clk;
    logic          rst;
    logic          sample_tick;
    logic          ev_valid;
    logic [VW-1:0] ev_voice;
    logic          ev_press;
    logic [2:0]    stp_state;
    logic [17:0]   stp_volume;
    logic          stp_pressed;
    logic          stp_released;
    logic [2:0]    stp_next_state;
    logic [17:0]   stp_next_volume;
    logic          vol_valid;
    logic [VW-1:0] vol_voice;
    logic [17:0]   vol_out;
    logic          busy;
    logic          sweep_done;
    logic          overrun;

    voice_env_sched #(.NVOICE(N), .VW(VW)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .ev_valid(ev_valid), .ev_voice(ev_voice), .ev_press(ev_press),
        .stp_state(stp_state), .stp_volume(stp_volume),
        .stp_pressed(stp_pressed), .stp_released(stp_released),
        .stp_next_state(stp_next_state), .stp_next_volume(stp_next_volume),
        .vol_valid(vol_valid), .vol_voice(vol_voice), .vol_out(vol_out),
        .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic [17:0] vol;
    } step_t;

    typedef struct {
        logic [VW-1:0] v;
        logic [17:0]   vol;
    } exp_t;

    // Envelope stepper with attack_rate=8 at full velocity; release ramps down by the same rate.
    function automatic step_t env_step(input logic [2:0] st, input logic [17:0] vol,
                                       input logic pr, input logic rl);
        step_t r;
        r.st  = st;
        r.vol = vol;
        case (st)
            3'd0: if (pr) r.st = 3'd1;
            3'd1: begin
                if (rl) r.st = 3'd4;
                else    r.vol = vol + 18'(ATK);
            end
            3'd4: begin
                if (vol <= 18'(ATK)) begin
                    r.vol = '0;
                    r.st  = 3'd0;
                end else begin
                    r.vol = vol - 18'(ATK);
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    assign {stp_next_state, stp_next_volume} = env_step(stp_state, stp_volume, stp_pressed, stp_released);

    logic [2:0]  m_state [N];
    logic [17:0] m_vol   [N];
    logic        m_pr    [N];
    logic        m_rl    [N];
    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          beats = 0;

    always @(negedge clk) begin
        exp_t e;
        if (vol_valid === 1'b1) begin
            beats++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected got voice=%0d vol=%0d required no beat", vol_voice, vol_out);
            end else begin
                e = exp_q.pop_front();
                if (vol_voice !== e.v || vol_out !== e.vol) begin
                    bad++;
                    $display("FAIL beat got voice=%0d vol=%0d required voice=%0d vol=%0d",
                             vol_voice, vol_out, e.v, e.vol);
                end else begin
                    $display("beat voice=%0d vol=%0d ok", vol_voice, vol_out);
                end
            end
        end
    end

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            m_state[v] = '0;
            m_vol[v]   = '0;
            m_pr[v]    = 1'b0;
            m_rl[v]    = 1'b0;
        end
    endtask

    task automatic drive_event(input int v, input logic pr);
        ev_valid = 1'b1;
        ev_voice = VW'(v);
        ev_press = pr;
        step_cycle();
        ev_valid = 1'b0;
        m_pr[v]  = pr;
        m_rl[v]  = !pr;
    endtask

    // One sweep with optional mid-sweep event, extra tick, reset, or tick in the sweep_done cycle.
    task automatic do_sweep(input int ev_at, input int ev_v, input logic ev_p,
                            input int ov_at, input int rst_at, input bit done_tick);
        int    b0;
        step_t s;
        logic  ov_exp;
        b0 = beats;
        sample_tick = 1'b1;
        step_cycle();
        sample_tick = 1'b0;
        for (int c = 0; c < N; c++) begin
            total++;
            if (busy !== 1'b1 || stp_state !== m_state[c] || stp_volume !== m_vol[c] ||
                stp_pressed !== m_pr[c] || stp_released !== m_rl[c]) begin
                bad++;
                $display("FAIL present c=%0d got busy=%0b st=%0d vol=%0d pr=%0b rl=%0b required busy=1 st=%0d vol=%0d pr=%0b rl=%0b",
                         c, busy, stp_state, stp_volume, stp_pressed, stp_released,
                         m_state[c], m_vol[c], m_pr[c], m_rl[c]);
            end
            ov_exp = (ov_at >= 0) && (c == ov_at + 1);
            total++;
            if (overrun !== ov_exp) begin
                bad++;
                $display("FAIL overrun c=%0d got %0b required %0b", c, overrun, ov_exp);
            end
            if (c == rst_at) begin
                rst = 1'b1;
                step_cycle();
                rst = 1'b0;
                model_reset();
                total++;
                if (busy !== 1'b0 || vol_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_abort got busy=%0b vol_valid=%0b required 0 0", busy, vol_valid);
                end
                repeat (4) step_cycle();
                total++;
                if (beats - b0 != rst_at || exp_q.size() != 0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_beats got beats=%0d pending=%0d busy=%0b required beats=%0d pending=0 busy=0",
                             beats - b0, exp_q.size(), busy, rst_at);
                end
                $display("sweep aborted by reset at idx=%0d", rst_at);
                return;
            end
            if (c == ev_at) begin
                ev_valid = 1'b1;
                ev_voice = VW'(ev_v);
                ev_press = ev_p;
            end
            if (c == ov_at) sample_tick = 1'b1;
            s = env_step(m_state[c], m_vol[c], m_pr[c], m_rl[c]);
            m_state[c] = s.st;
            m_vol[c]   = s.vol;
            m_pr[c]    = 1'b0;
            m_rl[c]    = 1'b0;
            exp_q.push_back('{v: VW'(c), vol: s.vol});
            if (c == ev_at) begin
                m_pr[ev_v] = ev_p;
                m_rl[ev_v] = !ev_p;
            end
            step_cycle();
            ev_valid    = 1'b0;
            sample_tick = 1'b0;
        end
        total++;
        if (busy !== 1'b0 || sweep_done !== 1'b0) begin
            bad++;
            $display("FAIL sweep_end got busy=%0b done=%0b required 0 0", busy, sweep_done);
        end
        step_cycle();
        total++;
        if (sweep_done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL sweep_done got done=%0b busy=%0b required 1 0", sweep_done, busy);
        end
        if (done_tick) begin
            sample_tick = 1'b1;
            step_cycle();
            sample_tick = 1'b0;
            total++;
            if (overrun !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL done_tick got overrun=%0b busy=%0b required 1 0", overrun, busy);
            end
        end else begin
            step_cycle();
        end
        step_cycle();
        total++;
        if (sweep_done !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            beats - b0 != N || exp_q.size() != 0) begin
            bad++;
            $display("FAIL sweep_tail got done=%0b busy=%0b overrun=%0b beats=%0d pending=%0d required 0 0 0 %0d 0",
                     sweep_done, busy, overrun, beats - b0, exp_q.size(), N);
        end
        $display("sweep complete beats=%0d", beats - b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sample_tick = 1'b1;
        ev_valid = 1'b0;
        ev_voice = '0;
        ev_press = 1'b0;
        model_reset();
        step_cycle();
        step_cycle();
        rst = 1'b0;
        sample_tick = 1'b0;
        step_cycle();
        total++;
        if (busy !== 1'b0 || vol_valid !== 1'b0 || vol_voice !== '0 || vol_out !== '0 ||
            sweep_done !== 1'b0 || overrun !== 1'b0 || stp_state !== '0 || stp_volume !== '0 ||
            stp_pressed !== 1'b0 || stp_released !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got busy=%0b vv=%0b voice=%0d vol=%0d done=%0b ov=%0b st=%0d sv=%0d pr=%0b rl=%0b required all 0",
                     busy, vol_valid, vol_voice, vol_out, sweep_done, overrun,
                     stp_state, stp_volume, stp_pressed, stp_released);
        end
        $display("reset checked");
    endtask

    task automatic test_idle_sweeps();
        for (int k = 0; k < 3; k++) do_sweep(-1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_attack();
        drive_event(3, 1'b1);
        for (int k = 0; k < 3; k++) do_sweep(-1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_event_collision();
        do_sweep(5, 5, 1'b1, -1, -1, 1'b0);
        do_sweep(2, 9, 1'b1, -1, -1, 1'b0);
        do_sweep(-1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_latest_wins();
        drive_event(2, 1'b1);
        drive_event(2, 1'b0);
        do_sweep(-1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    task automatic test_overrun();
        do_sweep(-1, 0, 1'b0, 4, -1, 1'b1);
    endtask

    task automatic test_reset_mid_sweep();
        do_sweep(-1, 0, 1'b0, -1, 7, 1'b0);
        do_sweep(-1, 0, 1'b0, -1, -1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle_sweeps();
        test_attack();
        test_event_collision();
        test_latest_wins();
        test_overrun();
        test_reset_mid_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
